// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU sequencer with Y/Z capture; optional DIV_ZERO_TRAP_EN aborts divide-by-zero with error
module alu_seq (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [4:0]  opcode,
   input  logic [31:0] bus_in,
   input  logic [31:0] alu_chigh,
   input  logic [31:0] alu_clow,
   output logic [31:0] y_out,
   output logic [12:0] alu_op,
   output logic        rb_out,
   output logic        rc_out,
   output logic        ra_in,
   output logic        hi_in,
   output logic        lo_in,
   output logic [31:0] bus_out,
   output logic        zlo_out,
   output logic        zhi_out,
   output logic        busy,
   output logic        done,
   output logic        error
);
   typedef enum logic [2:0] {IDLE, LOAD_Y, EXEC, WB_LO, WB_HI} state_t;
   state_t state, state_n;
   logic [4:0]  op_q;
   logic [63:0] z;
   logic        err_q;
   logic        legal, unary_in, unary, wide, trap;
   function automatic logic [12:0] dec(input logic [4:0] op);
      case (op)
         5'b00011: dec = 13'h0001;
         5'b00100: dec = 13'h0002;
         5'b01111: dec = 13'h0004;
         5'b10000: dec = 13'h0008;
         5'b01010: dec = 13'h0010;
         5'b01011: dec = 13'h0020;
         5'b00101: dec = 13'h0040;
         5'b00110: dec = 13'h0080;
         5'b00111: dec = 13'h0100;
         5'b01000: dec = 13'h0200;
         5'b01001: dec = 13'h0400;
         5'b10001: dec = 13'h0800;
         5'b10010: dec = 13'h1000;
         default:  dec = 13'h0000;
      endcase
   endfunction
   assign legal    = |dec(opcode);
   assign unary_in = opcode == 5'b10001 || opcode == 5'b10010;
   assign unary    = op_q == 5'b10001 || op_q == 5'b10010;
   assign wide     = op_q == 5'b01111 || op_q == 5'b10000;
`ifdef DIV_ZERO_TRAP_EN
   assign trap = state == EXEC && op_q == 5'b10000 && bus_in == 32'h0;
`else
   assign trap = 1'b0;
`endif
   // state register
   always_ff @(posedge clk)
      if (clr) state <= IDLE;
      else     state <= state_n;
   // sequencing: IDLE dispatch, fixed walk through load/exec/writeback
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start && legal) state_n = unary_in ? EXEC : LOAD_Y;
         LOAD_Y:  state_n = EXEC;
         EXEC:    state_n = trap ? IDLE : WB_LO;
         WB_LO:   state_n = wide ? WB_HI : IDLE;
         default: state_n = IDLE;
      endcase
   end
   // opcode latch, Y/Z capture and the registered error pulse
   always_ff @(posedge clk)
      if (clr) begin
         op_q  <= '0;
         y_out <= '0;
         z     <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == IDLE && start) op_q <= opcode;
         if (state == LOAD_Y) y_out <= bus_in;
         if (state == EXEC && !trap) z <= {alu_chigh, alu_clow};
         err_q <= (state == IDLE && start && !legal) || trap;
      end
   // Moore strobes from state and latched opcode
   always_comb begin
      busy    = state != IDLE;
      rb_out  = state == LOAD_Y || (state == EXEC && unary);
      rc_out  = state == EXEC && !unary;
      alu_op  = state == EXEC ? dec(op_q) : 13'h0;
      zlo_out = state == WB_LO;
      zhi_out = state == WB_HI;
      lo_in   = state == WB_LO && wide;
      ra_in   = state == WB_LO && !wide;
      hi_in   = state == WB_HI;
      done    = ra_in || hi_in;
      bus_out = zlo_out ? z[31:0] : zhi_out ? z[63:32] : 32'h0;
      error   = err_q;
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized transaction-level check of alu_seq against a per-cycle expectation model
module tb_alu_seq;
   logic        clk = 0, clr = 1, start = 0;
   logic [4:0]  opcode = 0;
   logic [31:0] bus_in, alu_chigh, alu_clow, y_out, bus_out;
   logic [12:0] alu_op;
   logic        rb_out, rc_out, ra_in, hi_in, lo_in, zlo_out, zhi_out, busy, done, error;
   logic [31:0] rb_v = 0, rc_v = 0;
   typedef struct packed {
      logic busy, done, error, rb, rc, ra, hi, lo, zlo, zhi;
      logic [12:0] op;
      logic [31:0] bus, y;
   } obs_t;
   typedef struct {int cyc; obs_t o;} rec_t;
   localparam logic [4:0] CODES [13] = '{5'b00011, 5'b00100, 5'b01111, 5'b10000, 5'b01010, 5'b01011,
                                         5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b10001, 5'b10010};
   localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, MUL = 5'b01111, DIV = 5'b10000, NEG = 5'b10001, NOT = 5'b10010;
   rec_t q[$];
   obs_t dut_o;
   int cyc = 0, errors = 0, checks = 0;
   bit chk_en = 0;
   logic [31:0] idle_y = 0, model_y = 0, last_done_bus = 0;

   alu_seq dut (.clk(clk), .clr(clr), .start(start), .opcode(opcode), .bus_in(bus_in),
      .alu_chigh(alu_chigh), .alu_clow(alu_clow), .y_out(y_out), .alu_op(alu_op),
      .rb_out(rb_out), .rc_out(rc_out), .ra_in(ra_in), .hi_in(hi_in), .lo_in(lo_in),
      .bus_out(bus_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .busy(busy), .done(done), .error(error));

   always #5 clk = ~clk;

   function automatic int idx_of(input logic [4:0] c);
      for (int i = 0; i < 13; i++) if (CODES[i] == c) return i;
      return -1;
   endfunction
   function automatic logic [4:0] code_of(input logic [12:0] h);
      for (int i = 0; i < 13; i++) if (h == (13'd1 << i)) return CODES[i];
      return 5'd0;
   endfunction
   // ALU behaviour: {Chigh, Clow}
   function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0] t;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         5'b00011: return {32'h0, a + b};
         5'b00100: return {32'h0, a - b};
         5'b00101: return {32'h0, a >> b[4:0]};
         5'b00110: return {32'h0, 32'($signed(a) >>> b[4:0])};
         5'b00111: return {32'h0, a << b[4:0]};
         5'b01000: begin t = {a, a} >> b[4:0]; return {32'h0, t[31:0]}; end
         5'b01001: begin t = {a, a} << b[4:0]; return {32'h0, t[63:32]}; end
         5'b01010: return {32'h0, a & b};
         5'b01011: return {32'h0, a | b};
         5'b01111: return 64'(sa * sb);
         5'b10000: return b == 0 ? 64'h0 : {a % b, a / b};
         5'b10001: return {32'h0, -b};
         5'b10010: return {32'h0, ~b};
         default:  return 64'h0;
      endcase
   endfunction

   assign bus_in = rb_out ? rb_v : rc_out ? rc_v : 32'h0;
   always_comb {alu_chigh, alu_clow} = alu_f(code_of(alu_op), y_out, bus_in);
   always_comb dut_o = {busy, done, error, rb_out, rc_out, ra_in, hi_in, lo_in, zlo_out, zhi_out, alu_op, bus_out, y_out};

   always @(posedge clk) cyc <= cyc + 1;

   // single compare point: scheduled expectation for this cycle, otherwise quiet IDLE
   always @(negedge clk) if (chk_en) begin : cmp
      obs_t e;
      e = '0;
      e.y = idle_y;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q[0].o;
         void'(q.pop_front());
         idle_y = e.y;
      end
      checks++;
      if (dut_o !== e) begin
         errors++;
         $display("FAIL cycle%0d got=%h exp=%h", cyc, dut_o, e);
      end
      if (dut_o.done) last_done_bus = dut_o.bus;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit chain);
      obs_t r[4];
      int n, ix;
      logic [63:0] res;
      @(posedge clk); #1;
      start = 1; opcode = op; rb_v = a; rc_v = b;
      ix = idx_of(op);
      for (int k = 0; k < 4; k++) r[k] = '0;
      if (ix < 0) begin
         n = 1;
         r[0].error = 1; r[0].y = model_y;
      end else if (op == NEG || op == NOT) begin
         n = 2;
         res = alu_f(op, model_y, a);
         r[0].busy = 1; r[0].rb = 1; r[0].op = 13'd1 << ix; r[0].y = model_y;
         r[1].busy = 1; r[1].zlo = 1; r[1].ra = 1; r[1].done = 1; r[1].bus = res[31:0]; r[1].y = model_y;
      end else begin
         res = alu_f(op, a, b);
         r[0].busy = 1; r[0].rb = 1; r[0].y = model_y;
         model_y = a;
         r[1].busy = 1; r[1].rc = 1; r[1].op = 13'd1 << ix; r[1].y = a;
         r[2].y = a; r[3].y = a;
`ifdef DIV_ZERO_TRAP_EN
         if (op == DIV && b == 0) begin
            n = 3;
            r[2].error = 1;
         end else
`endif
         if (op == MUL || op == DIV) begin
            n = 4;
            r[2].busy = 1; r[2].zlo = 1; r[2].lo = 1; r[2].bus = res[31:0];
            r[3].busy = 1; r[3].zhi = 1; r[3].hi = 1; r[3].done = 1; r[3].bus = res[63:32];
         end else begin
            n = 3;
            r[2].busy = 1; r[2].zlo = 1; r[2].ra = 1; r[2].done = 1; r[2].bus = res[31:0];
         end
      end
      for (int k = 0; k < n; k++) q.push_back('{cyc + 1 + k, r[k]});
      for (int k = 1; k <= n - (chain ? 1 : 0); k++) begin
         @(posedge clk); #1;
         start = k < n ? 1'($urandom_range(0, 1)) : 1'b0;
         opcode = 5'($urandom);
      end
   endtask

   initial begin
      obs_t r;
      start = 1; opcode = ADD;
      repeat (3) @(posedge clk);
      #1 clr = 0; start = 0; chk_en = 1;
      chk("model_add", alu_f(ADD, 5, 7), 64'd12);
      chk("model_mul", alu_f(MUL, 32'hFFFFFFFE, 3), 64'hFFFFFFFF_FFFFFFFA);
      chk("model_neg", alu_f(NEG, 0, 1), 64'h0_FFFFFFFF);
      chk("model_ror", alu_f(5'b01000, 32'h0000_0001, 4), 64'h0_10000000);
      do_op(ADD, 5, 7, 0);
      @(negedge clk); #1 chk("add_done_bus", {32'h0, last_done_bus}, 64'd12);
      do_op(MUL, 32'hFFFFFFFE, 3, 0);
      @(negedge clk); #1 chk("mul_done_bus", {32'h0, last_done_bus}, 64'hFFFFFFFF);
      do_op(NEG, 1, 0, 0);
      @(negedge clk); #1 chk("neg_done_bus", {32'h0, last_done_bus}, 64'hFFFFFFFF);
      do_op(5'b00000, 0, 0, 1);
      do_op(ADD, 3, 4, 0);
      do_op(DIV, 100, 0, 0);
      do_op(DIV, 100, 7, 0);
      // clr in EXEC of a SUB with start held high
      @(posedge clk); #1;
      start = 1; opcode = SUB; rb_v = 9; rc_v = 4;
      r = '0; r.busy = 1; r.rb = 1; r.y = model_y;
      q.push_back('{cyc + 1, r});
      r = '0; r.busy = 1; r.rc = 1; r.op = 13'h0002; r.y = 9;
      q.push_back('{cyc + 2, r});
      r = '0;
      q.push_back('{cyc + 3, r});
      model_y = 0;
      @(posedge clk); #1 start = 0;
      @(posedge clk); #1 clr = 1; start = 1; opcode = ADD;
      @(posedge clk); #1 clr = 0; start = 0;
      for (int i = 0; i < 80; i++) begin
         logic [4:0] op;
         logic [31:0] a, b;
         op = $urandom_range(0, 9) == 0 ? 5'($urandom) : CODES[$urandom_range(0, 12)];
         a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : 32'($urandom);
         b = $urandom_range(0, 5) == 0 ? 32'h0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 40)) : 32'($urandom);
         do_op(op, a, b, $urandom_range(0, 1) == 1 && idx_of(op) < 0);
      end
      repeat (4) @(posedge clk);
      #1 chk("queue_drained", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
